// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a one-cycle fast path for divide-by-zero and signed overflow.
module mul_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] rs1,
    input  logic [DATA_WIDTH-1:0] rs2,
    input  logic                  stall,
    input  logic                  clear,
    output logic                  busy,
    output logic                  resultValid,
    output logic [DATA_WIDTH-1:0] result
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DATA_WIDTH - 1);
    localparam logic [W-1:0]  MIN_INT    = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   counter_reg;
    logic [W-1:0]    hi_reg, lo_reg, b_reg, result_reg;
    logic [2:0]      op_reg;
    logic            neg_main_reg, neg_rem_reg;

    // Operand decode for the instruction presented in IDLE
    logic            is_div, signed_a, signed_b, a_neg, b_neg;
    logic            div_zero, div_overflow, fast_path, accept;
    logic [W-1:0]    a_abs, b_abs, fast_result;

    always_comb begin
        is_div       = op[2];
        signed_a     = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        signed_b     = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        a_neg        = signed_a & rs1[W-1];
        b_neg        = signed_b & rs2[W-1];
        a_abs        = a_neg ? -rs1 : rs1;
        b_abs        = b_neg ? -rs2 : rs2;
        div_zero     = is_div && (rs2 == '0);
        div_overflow = ((op == 3'd4) || (op == 3'd6)) && (rs1 == MIN_INT) && (rs2 == '1);
        fast_path    = div_zero || div_overflow;
        accept       = start && !clear;
        fast_result  = '0;
        if (div_zero) begin
            fast_result = op[1] ? rs1 : '1;
        end else if (div_overflow) begin
            fast_result = op[1] ? '0 : MIN_INT;
        end
    end

    // One iteration of either algorithm; hi holds accumulator/remainder,
    // lo holds multiplier/dividend-becoming-quotient, b holds multiplicand/divisor.
    logic [W:0]      add_sum, shifted;
    logic            div_ge;
    logic [W-1:0]    hi_next, lo_next;
    logic [2*W-1:0]  prod_full, prod_fixed;
    logic [W-1:0]    quo_fixed, rem_fixed, final_result;
    logic            last_iter;

    always_comb begin
        add_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : {(W+1){1'b0}});
        shifted = {hi_reg, lo_reg[W-1]};
        div_ge  = shifted >= {1'b0, b_reg};
        if (op_reg[2]) begin
            hi_next = div_ge ? W'(shifted - {1'b0, b_reg}) : shifted[W-1:0];
            lo_next = {lo_reg[W-2:0], div_ge};
        end else begin
            hi_next = add_sum[W:1];
            lo_next = {add_sum[0], lo_reg[W-1:1]};
        end
        prod_full  = {hi_next, lo_next};
        prod_fixed = neg_main_reg ? -prod_full : prod_full;
        quo_fixed  = neg_main_reg ? -lo_next : lo_next;
        rem_fixed  = neg_rem_reg ? -hi_next : hi_next;
        if (op_reg[2]) begin
            final_result = op_reg[1] ? rem_fixed : quo_fixed;
        end else begin
            final_result = (op_reg == 3'd0) ? prod_fixed[W-1:0] : prod_fixed[2*W-1:W];
        end
        last_iter = (counter_reg == LAST_COUNT);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = fast_path ? DONE : CALC;
                end
            end
            CALC: begin
                if (clear) begin
                    state_next = IDLE;
                end else if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (clear || !stall) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs: busy must be combinational so the controller stalls on the start cycle
    always_comb begin
        busy        = !rst && !clear &&
                      ((start && (state_reg == IDLE)) || (state_reg == CALC));
        resultValid = (state_reg == DONE);
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            counter_reg  <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            b_reg        <= '0;
            op_reg       <= '0;
            neg_main_reg <= 1'b0;
            neg_rem_reg  <= 1'b0;
            result_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    counter_reg <= '0;
                    if (accept) begin
                        hi_reg       <= '0;
                        lo_reg       <= a_abs;
                        b_reg        <= b_abs;
                        op_reg       <= op;
                        neg_main_reg <= a_neg ^ b_neg;
                        neg_rem_reg  <= a_neg;
                        if (fast_path) begin
                            result_reg <= fast_result;
                        end
                    end
                end
                CALC: begin
                    if (clear) begin
                        counter_reg <= '0;
                    end else begin
                        counter_reg <= counter_reg + 1'b1;
                        hi_reg      <= hi_next;
                        lo_reg      <= lo_next;
                        if (last_iter) begin
                            result_reg <= final_result;
                        end
                    end
                end
                default: begin
                    counter_reg <= '0;
                end
            endcase
        end
    end

    assign result = result_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized scoreboard bench for mul_div_unit: driver pushes model results,
// a monitor pops and compares whenever resultValid rises.
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        rst, start, stall, clear;
    logic [2:0]  op;
    logic [31:0] rs1, rs2;
    logic        busy, resultValid;
    logic [31:0] result;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    mul_div_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
        .stall(stall), .clear(clear), .busy(busy), .resultValid(resultValid),
        .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model from the RV32M definitions using 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, p;
        longint unsigned ua, ub, up;
        int              ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        ia = int'(a);
        ib = int'(b);
        case (o)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[2] && (b == 0)) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Monitor: one expected value per DONE episode, held for its whole duration
    initial begin
        logic        prev_valid;
        logic        have;
        logic [31:0] cur;
        prev_valid = 1'b0;
        have       = 1'b0;
        cur        = '0;
        forever begin
            @(negedge clk);
            if (resultValid) begin
                if (!prev_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_valid actual=%h required=none", result);
                        have = 1'b0;
                    end else begin
                        cur  = exp_q.pop_front();
                        have = 1'b1;
                    end
                end
                if (have) check("result", result, cur);
            end
            prev_valid = resultValid;
        end
    end

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int nstall);
        int cyc;
        int lat;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        rs1   = a;
        rs2   = b;
        stall = 1'b0;
        exp_q.push_back(ref_model(o, a, b));
        lat = ref_latency(o, a, b);
        #1;
        cyc = 0;
        while (!resultValid && cyc < 100) begin
            check("busy_active", busy, 1'b1);
            @(negedge clk);
            cyc++;
            rs1 = $urandom;
            rs2 = $urandom;
            #1;
        end
        if (!resultValid) begin
            checks++;
            errors++;
            $display("FAIL timeout actual=%0d required=%0d", cyc, lat);
        end
        check("latency", cyc, lat);
        check("busy_done", busy, 1'b0);
        for (int k = 0; k < nstall; k++) begin
            stall = 1'b1;
            @(negedge clk);
            #1;
            check("held_valid", resultValid, 1'b1);
        end
        stall = 1'b0;
        start = 1'b0;
        @(negedge clk);
        #1;
        check("idle_valid", resultValid, 1'b0);
        check("idle_busy", busy, 1'b0);
        $display("op=%0d rs1=%h rs2=%h latency=%0d stall=%0d", o, a, b, cyc, nstall);
    endtask

    initial begin
        logic [31:0] specials [4];
        logic [31:0] a, b;
        specials[0] = 32'h0;
        specials[1] = 32'hFFFF_FFFF;
        specials[2] = 32'h8000_0000;
        specials[3] = 32'h1;

        rst = 1'b1; start = 1'b0; stall = 1'b0; clear = 1'b0;
        op = '0; rs1 = '0; rs2 = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_busy", busy, 1'b0);
        check("reset_valid", resultValid, 1'b0);
        check("reset_result", result, 32'h0);
        rst = 1'b0;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd5, 32'd100, 32'd7, 0);
        run_op(3'd7, 32'd100, 32'd7, 3);
        run_op(3'd5, 32'd5, 32'd0, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 2);

        // Abort in the middle of CALC, then restart two cycles later
        @(negedge clk);
        start = 1'b1; op = 3'd0; rs1 = 32'd123; rs2 = 32'd456;
        repeat (10) @(negedge clk);
        clear = 1'b1;
        #1;
        check("clear_busy", busy, 1'b0);
        @(negedge clk);
        clear = 1'b0;
        start = 1'b0;
        #1;
        check("clear_valid", resultValid, 1'b0);
        check("clear_idle_busy", busy, 1'b0);
        @(negedge clk);
        run_op(3'd0, 32'd1000, 32'd3, 0);

        // Reset in the middle of CALC after a nonzero result is held
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        @(negedge clk);
        start = 1'b1; op = 3'd5; rs1 = 32'd999; rs2 = 32'd10;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_valid", resultValid, 1'b0);
        check("rst_result", result, 32'h0);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : 32'($urandom);
            b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : 32'($urandom);
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(16, 31);
            run_op(3'($urandom_range(0, 7)), a, b, $urandom_range(0, 2));
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
